// File: rtl/adc_serial_emulator_if.sv
// Parallel-word input side and serial-lane output side of the ADC lane emulator.
// Handshake: a word transfers on a rising clk edge where valid & ready; ready is registered.
interface adc_serial_emulator_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]         data;
    logic                     valid;
    logic                     ready;
    logic                     train;
    logic                     slip;
    logic                     d;
    logic                     frame;
    logic                     underrun;
    logic [$clog2(WIDTH)-1:0] slip_cnt;
    logic                     dbg_state;

    modport master (
        output data, valid, train, slip,
        input  ready, d, frame, underrun, slip_cnt, dbg_state
    );

    modport slave (
        input  data, valid, train, slip,
        output ready, d, frame, underrun, slip_cnt, dbg_state
    );
endinterface

// File: rtl/adc_serial_emulator.sv
// Bit-clock serializer emulating one ADC LVDS lane: serial data plus frame marker,
// with a one-entry holding register, training pattern and bit-slip injection.
module adc_serial_emulator #(
    parameter int               WIDTH         = 8,
    parameter bit               LSB_FIRST     = 1'b1,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'hF0,
    parameter logic [WIDTH-1:0] IDLE_WORD     = 8'h00
) (
    input logic                   clk,
    input logic                   rst,
    adc_serial_emulator_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bcnt;
    logic             ready_r;
    logic             d_r;
    logic             frame_r;
    logic             underrun_r;
    logic             slip_q;
    logic             slip_pend;
    logic [CW-1:0]    slip_cnt_r;

    logic             xfer;
    logic             slip_rise;
    logic [WIDTH-1:0] next_word;
    logic             take_hold;
    logic             idle_load;
    logic [CW-1:0]    nxt_idx;

    function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [CW-1:0] k);
        logic [CW-1:0] idx;
        idx = LSB_FIRST ? k : LAST - k;
        return w[idx];
    endfunction

    assign xfer      = bus.valid & ready_r;
    assign slip_rise = bus.slip & ~slip_q;
    assign nxt_idx   = bcnt + CW'(1);

    // Training outranks the holding register, which is left untouched while training.
    always_comb begin
        next_word = IDLE_WORD;
        take_hold = 1'b0;
        idle_load = 1'b0;
        if (bus.train) begin
            next_word = TRAIN_PATTERN;
        end else if (hold_full) begin
            next_word = hold;
            take_hold = 1'b1;
        end else begin
            idle_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            hold       <= '0;
            hold_full  <= 1'b0;
            shreg      <= '0;
            bcnt       <= '0;
            ready_r    <= 1'b0;
            d_r        <= 1'b0;
            frame_r    <= 1'b0;
            underrun_r <= 1'b0;
            slip_q     <= 1'b0;
            slip_pend  <= 1'b0;
            slip_cnt_r <= '0;
        end else begin
            slip_q     <= bus.slip;
            underrun_r <= 1'b0;
            // ready rises only one edge after the hold has been emptied by a load.
            ready_r    <= ~xfer & ~hold_full;
            if (slip_rise && !slip_pend) begin
                slip_pend <= 1'b1;
            end
            if (xfer) begin
                hold      <= bus.data;
                hold_full <= 1'b1;
            end
            case (state)
                S_INIT: begin
                    shreg   <= next_word;
                    d_r     <= bit_at(next_word, '0);
                    frame_r <= 1'b1;
                    bcnt    <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (bcnt == LAST && slip_pend) begin
                        // Stretch the word by one cycle: d, frame and bcnt simply hold.
                        slip_pend  <= 1'b0;
                        slip_cnt_r <= (slip_cnt_r == LAST) ? '0 : slip_cnt_r + CW'(1);
                    end else if (bcnt == LAST) begin
                        shreg      <= next_word;
                        d_r        <= bit_at(next_word, '0);
                        frame_r    <= 1'b1;
                        bcnt       <= '0;
                        underrun_r <= idle_load;
                        if (take_hold) begin
                            hold_full <= 1'b0;
                        end
                    end else begin
                        bcnt    <= nxt_idx;
                        d_r     <= bit_at(shreg, nxt_idx);
                        frame_r <= (nxt_idx < HALF);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.ready     = ready_r;
    assign bus.d         = d_r;
    assign bus.frame     = frame_r;
    assign bus.underrun  = underrun_r;
    assign bus.slip_cnt  = slip_cnt_r;
    assign bus.dbg_state = (state == S_RUN);
endmodule
